register_writeback_queue: RTL and testbench

Buffers register-file write requests from execution units and drains them one per cycle into the `Registers` block's write port (`writeRegister`/`writeValue`). It is the producer side of the register file's write interface. It holds a small in-order FIFO so a producer is not blocked while the write port is stalled, for example during a MOV transfer. A bypass lookup port returns the newest pending value for any register, so readers never see stale data for a write still in the queue.

---
 rtl/register_writeback_queue.sv | 99 +++++++++
 tb/tb_register_writeback_queue.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/register_writeback_queue.sv
// Purpose: in-order FIFO of register-file writes with newest-value bypass lookup.
// Latency: push at edge N is presented on writeRegister/writeValue during cycle N->N+1.
// Backpressure: inReady drops when full; stall holds the head entry without popping.
module register_writeback_queue #(
  parameter int RegisterSize      = 32,
  parameter int AmountOfRegisters = 16,
  parameter int Depth             = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 inValid,
  output logic                                 inReady,
  input  logic [$clog2(AmountOfRegisters)-1:0] inRegister,
  input  logic [RegisterSize-1:0]              inValue,
  input  logic                                 stall,
  output logic                                 writeEnable,
  output logic [$clog2(AmountOfRegisters)-1:0] writeRegister,
  output logic [RegisterSize-1:0]              writeValue,
  input  logic [$clog2(AmountOfRegisters)-1:0] lookupRegister,
  output logic                                 lookupHit,
  output logic [RegisterSize-1:0]              lookupValue,
  output logic [$clog2(Depth+1)-1:0]           count,
  output logic                                 full,
  output logic                                 empty
);

  localparam int IW = $clog2(AmountOfRegisters);
  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);

  logic [IW-1:0]           r_reg [Depth];
  logic [RegisterSize-1:0] r_val [Depth];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_hit;
  logic [RegisterSize-1:0] w_lval;
  logic [PW-1:0]           w_idx;

  // Status flags come straight from the registered occupancy count.
  assign full        = (r_count == CW'(Depth));
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign inReady     = !full;
  assign writeEnable = !empty && !stall;

  assign w_push = inValid && inReady;
  assign w_pop  = writeEnable;

  assign writeRegister = empty ? '0 : r_reg[r_rd_ptr];
  assign writeValue    = empty ? '0 : r_val[r_rd_ptr];
  assign lookupHit     = w_hit;
  assign lookupValue   = w_lval;

  // Walk occupied entries oldest to newest so the newest match overrides older ones.
  always_comb begin
    w_hit  = 1'b0;
    w_lval = '0;
    w_idx  = '0;
    for (int i = 0; i < Depth; i++) begin
      w_idx = r_rd_ptr + PW'(i);
      if ((CW'(i) < r_count) && (r_reg[w_idx] == lookupRegister)) begin
        w_hit  = 1'b1;
        w_lval = r_val[w_idx];
      end
    end
  end

  // Entry storage: written at the write pointer on an accepted push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_reg[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (w_push) begin
      r_reg[r_wr_ptr] <= inRegister;
      r_val[r_wr_ptr] <= inValue;
    end
  end

  // Pointers wrap naturally at Depth (power of two); count separates full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_register_writeback_queue.sv
module tb_register_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inRegister;
  logic [31:0] inValue;
  logic        stall;
  logic        writeEnable;
  logic [3:0]  writeRegister;
  logic [31:0] writeValue;
  logic [3:0]  lookupRegister;
  logic        lookupHit;
  logic [31:0] lookupValue;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] v;
  } ent_t;

  ent_t        m_q[$];
  logic [35:0] dut_log[$];
  logic [35:0] exp_log[$];

  always #5 clk = ~clk;

  register_writeback_queue dut (
    .clk(clk), .reset(reset),
    .inValid(inValid), .inReady(inReady), .inRegister(inRegister), .inValue(inValue),
    .stall(stall), .writeEnable(writeEnable), .writeRegister(writeRegister), .writeValue(writeValue),
    .lookupRegister(lookupRegister), .lookupHit(lookupHit), .lookupValue(lookupValue),
    .count(count), .full(full), .empty(empty)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes, 4 slots.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
    end else begin
      bit do_push, do_pop;
      do_push = inValid && (m_q.size() < 4);
      do_pop  = (m_q.size() > 0) && !stall;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back('{r: inRegister, v: inValue});
    end
  end

  // Per-cycle comparison of every output against the model, plus a log of issued writes.
  always @(negedge clk) begin
    if (writeEnable) dut_log.push_back({writeRegister, writeValue});
    if (check_en && reset) begin
      logic        e_hit;
      logic [31:0] e_lval;
      int          n;
      n      = m_q.size();
      e_hit  = 1'b0;
      e_lval = '0;
      for (int i = 0; i < n; i++) begin
        if (m_q[i].r == lookupRegister) begin
          e_hit  = 1'b1;
          e_lval = m_q[i].v;
        end
      end
      check("m_count",   64'(count),       64'(n));
      check("m_full",    64'(full),        64'(n == 4));
      check("m_empty",   64'(empty),       64'(n == 0));
      check("m_inReady", 64'(inReady),     64'(n != 4));
      check("m_we",      64'(writeEnable), 64'((n > 0) && !stall));
      check("m_wreg",    64'(writeRegister), (n > 0) ? 64'(m_q[0].r) : 64'd0);
      check("m_wval",    64'(writeValue),    (n > 0) ? 64'(m_q[0].v) : 64'd0);
      check("m_lhit",    64'(lookupHit),   64'(e_hit));
      check("m_lval",    64'(lookupValue), 64'(e_lval));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] r, input logic [31:0] v);
    bit taken;
    taken      = 1'b0;
    inValid    = 1'b1;
    inRegister = r;
    inValue    = v;
    for (int k = 0; k < 20 && !taken; k++) begin
      bit rdy;
      @(negedge clk);
      rdy = inReady;
      tick();
      if (rdy) taken = 1'b1;
    end
    inValid = 1'b0;
    checks++;
    if (!taken) begin
      failures++;
      $display("FAIL push_timeout: reg %0d not accepted within 20 cycles", r);
    end
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, 64'(dut_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
      check(name, 64'(dut_log[i]), 64'(exp_log[i]));
  endtask

  task automatic check_idle(input string name);
    check({name, "_count"}, 64'(count), 64'd0);
    check({name, "_empty"}, 64'(empty), 64'd1);
    check({name, "_inReady"}, 64'(inReady), 64'd1);
    check({name, "_full"}, 64'(full), 64'd0);
    check({name, "_we"}, 64'(writeEnable), 64'd0);
    check({name, "_wreg"}, 64'(writeRegister), 64'd0);
    check({name, "_wval"}, 64'(writeValue), 64'd0);
    check({name, "_lhit"}, 64'(lookupHit), 64'd0);
    check({name, "_lval"}, 64'(lookupValue), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; inValid = 1'b0; inRegister = '0; inValue = '0;
    stall = 1'b0; lookupRegister = '0;

    // Reset state.
    tick(); tick();
    check_idle("reset");
    reset = 1'b1;
    check_en = 1'b1;
    tick();

    // Single pass-through.
    dut_log.delete();
    push(4'd3, 32'hDEADBEEF);
    check("pass_we",   64'(writeEnable),   64'd1);
    check("pass_wreg", 64'(writeRegister), 64'd3);
    check("pass_wval", 64'(writeValue),    64'hDEADBEEF);
    tick();
    check("pass_empty", 64'(empty), 64'd1);
    check("pass_we0",   64'(writeEnable), 64'd0);

    // Fill under stall, reject a fifth request, then drain in order.
    stall = 1'b1;
    push(4'd1, 32'h11); push(4'd2, 32'h22); push(4'd3, 32'h33); push(4'd4, 32'h44);
    check("fill_full",    64'(full),    64'd1);
    check("fill_inReady", 64'(inReady), 64'd0);
    check("fill_count",   64'(count),   64'd4);
    inValid = 1'b1; inRegister = 4'd9; inValue = 32'h99;
    tick(); tick();
    check("fill_5th_count", 64'(count), 64'd4);
    inValid = 1'b0;
    dut_log.delete();
    stall = 1'b0;
    repeat (4) tick();
    check("drain_empty", 64'(empty), 64'd1);
    exp_log = '{{4'd1, 32'h11}, {4'd2, 32'h22}, {4'd3, 32'h33}, {4'd4, 32'h44}};
    check_log("drain_order");

    // Newest-wins lookup.
    stall = 1'b1;
    dut_log.delete();
    push(4'd5, 32'hA); push(4'd7, 32'hB); push(4'd5, 32'hC);
    lookupRegister = 4'd5; #1;
    check("lk5_hit", 64'(lookupHit), 64'd1);
    check("lk5_val", 64'(lookupValue), 64'hC);
    lookupRegister = 4'd7; #1;
    check("lk7_val", 64'(lookupValue), 64'hB);
    lookupRegister = 4'd9; #1;
    check("lk9_hit", 64'(lookupHit), 64'd0);
    check("lk9_val", 64'(lookupValue), 64'd0);
    lookupRegister = 4'd5;
    stall = 1'b0;
    repeat (3) tick();
    check("lk_after_hit", 64'(lookupHit), 64'd0);
    exp_log = '{{4'd5, 32'hA}, {4'd7, 32'hB}, {4'd5, 32'hC}};
    check_log("lk_order");

    // Simultaneous push and pop with count held at 2.
    stall = 1'b1;
    push(4'd1, 32'h100); push(4'd2, 32'h200);
    dut_log.delete();
    stall = 1'b0;
    inValid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      inRegister = 4'(k + 8);
      inValue    = 32'h1000 + 32'(k);
      tick();
      check("sim_count", 64'(count), 64'd2);
    end
    inValid = 1'b0;
    tick(); tick();
    check("sim_empty", 64'(empty), 64'd1);
    exp_log = '{{4'd1, 32'h100}, {4'd2, 32'h200},
                {4'd8, 32'h1000}, {4'd9, 32'h1001}, {4'd10, 32'h1002}, {4'd11, 32'h1003},
                {4'd12, 32'h1004}, {4'd13, 32'h1005}, {4'd14, 32'h1006}, {4'd15, 32'h1007}};
    check_log("sim_order");

    // Stall mid-drain with head {R2, 0x55}.
    dut_log.delete();
    push(4'd6, 32'h66); push(4'd2, 32'h55);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("st_we",   64'(writeEnable),   64'd0);
      check("st_wreg", 64'(writeRegister), 64'd2);
      check("st_wval", 64'(writeValue),    64'h55);
      tick();
    end
    stall = 1'b0;
    tick(); tick();
    exp_log = '{{4'd6, 32'h66}, {4'd2, 32'h55}};
    check_log("st_once");

    // Asynchronous reset mid-operation with two entries queued.
    stall = 1'b1;
    push(4'd4, 32'h4444); push(4'd5, 32'h5555);
    check("rst_pre_count", 64'(count), 64'd2);
    #2 reset = 1'b0;
    #1;
    check_idle("rst_mid");
    tick();
    reset = 1'b1;
    stall = 1'b0;
    dut_log.delete();
    repeat (3) tick();
    check("rst_no_write", 64'(dut_log.size()), 64'd0);
    check("rst_post_empty", 64'(empty), 64'd1);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
